// File: rtl/snake_vga_renderer_pkg.sv
// Shared constants for the snake VGA renderer: entity codes, grid pitch,
// default 640x480@60 timing and the 12-bit colour palette.
package snake_vga_renderer_pkg;

    typedef enum logic [1:0] {
        ENT_NOTHING    = 2'd0,
        ENT_SNAKE_HEAD = 2'd1,
        ENT_SNAKE_TAIL = 2'd2,
        ENT_APPLE      = 2'd3
    } entity_t;

    localparam int H_SQUARE = 16;
    localparam int V_SQUARE = 16;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    localparam int H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    localparam logic [11:0] COL_HEAD    = 12'hFF0;
    localparam logic [11:0] COL_TAIL    = 12'h0A0;
    localparam logic [11:0] COL_APPLE   = 12'hF00;
    localparam logic [11:0] COL_BG      = 12'h000;
    localparam logic [11:0] COL_BG_OVER = 12'h400;
    localparam logic [11:0] COL_BG_WON  = 12'h006;
    localparam logic [11:0] COL_GRID    = 12'h222;

    // Won beats lost when both flags are up.
    function automatic logic [11:0] bg_colour(input logic over, input logic won);
        if (won)
            return COL_BG_WON;
        else if (over)
            return COL_BG_OVER;
        else
            return COL_BG;
    endfunction

endpackage

// File: rtl/snake_vga_renderer_vga_timing_gen.sv
// VGA raster counters with unregistered active/sync decode and a
// registered start-of-vertical-blank frame pulse.
module vga_timing_gen
    import snake_vga_renderer_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK
) (
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       active,
    output logic       hs_n,
    output logic       vs_n,
    output logic       frame_tick
);

    localparam logic [9:0] H_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] H_VIS   = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS   = 10'(V_VISIBLE);
    localparam logic [9:0] HS_FROM = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_TO   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_FROM = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_TO   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0] h_next;
    logic [9:0] v_next;

    // Next raster position: h wraps every line, v steps on the h wrap
    always_comb begin
        h_next = h_cnt + 10'd1;
        v_next = v_cnt;
        if (h_cnt == H_LAST) begin
            h_next = '0;
            v_next = (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
        end
    end

    // Counter registers; the frame pulse is decoded from the next position
    // so it is high exactly while the counters read (0, V_VISIBLE)
    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt      <= '0;
            v_cnt      <= '0;
            frame_tick <= 1'b0;
        end else begin
            h_cnt      <= h_next;
            v_cnt      <= v_next;
            frame_tick <= (h_next == '0) && (v_next == V_VIS);
        end
    end

    assign active = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    assign hs_n   = !((h_cnt >= HS_FROM) && (h_cnt < HS_TO));
    assign vs_n   = !((v_cnt >= VS_FROM) && (v_cnt < VS_TO));

endmodule

// File: rtl/snake_vga_renderer.sv
// Snake pixel renderer: VGA timing, entity-aligned colour map, update divider.
// Optional grid overlay on empty cells when SNAKE_GRID_LINES_EN is defined.
module snake_vga_renderer
    import snake_vga_renderer_pkg::*;
#(
    parameter int H_VISIBLE         = DEF_H_VISIBLE,
    parameter int H_FRONT           = DEF_H_FRONT,
    parameter int H_SYNC            = DEF_H_SYNC,
    parameter int H_BACK            = DEF_H_BACK,
    parameter int V_VISIBLE         = DEF_V_VISIBLE,
    parameter int V_FRONT           = DEF_V_FRONT,
    parameter int V_SYNC            = DEF_V_SYNC,
    parameter int V_BACK            = DEF_V_BACK,
    parameter int ENTITY_LATENCY    = 1,
    parameter int FRAMES_PER_UPDATE = 8
) (
    input  logic       vga_clk,
    input  logic       reset,
    input  logic [1:0] entity,
    input  logic       game_over,
    input  logic       game_won,
    output logic [9:0] x_out,
    output logic [9:0] y_out,
    output logic       hsync,
    output logic       vsync,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic       frame_tick,
    output logic       update_tick
);

    localparam int         L          = ENTITY_LATENCY;
    localparam logic [7:0] FRAME_LAST = 8'(FRAMES_PER_UPDATE - 1);

    logic [9:0]   h_cnt;
    logic [9:0]   v_cnt;
    logic         active;
    logic         hs_n;
    logic         vs_n;
    logic [L-1:0] active_d;
    logic [L-1:0] hs_d;
    logic [L-1:0] vs_d;
    logic [7:0]   frame_cnt;
    logic [11:0]  pixel;
    logic [11:0]  rgb;
    logic         grid;

    vga_timing_gen #(
        .H_VISIBLE (H_VISIBLE),
        .H_FRONT   (H_FRONT),
        .H_SYNC    (H_SYNC),
        .H_BACK    (H_BACK),
        .V_VISIBLE (V_VISIBLE),
        .V_FRONT   (V_FRONT),
        .V_SYNC    (V_SYNC),
        .V_BACK    (V_BACK)
    ) u_timing (
        .clk        (vga_clk),
        .reset      (reset),
        .h_cnt      (h_cnt),
        .v_cnt      (v_cnt),
        .active     (active),
        .hs_n       (hs_n),
        .vs_n       (vs_n),
        .frame_tick (frame_tick)
    );

    assign x_out = h_cnt;
    assign y_out = v_cnt;

    // Delay blanking and sync so they line up with the returned entity code
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            active_d <= '0;
            hs_d     <= '1;
            vs_d     <= '1;
        end else begin
            active_d[0] <= active;
            hs_d[0]     <= hs_n;
            vs_d[0]     <= vs_n;
            for (int i = 1; i < L; i++) begin
                active_d[i] <= active_d[i-1];
                hs_d[i]     <= hs_d[i-1];
                vs_d[i]     <= vs_d[i-1];
            end
        end
    end

`ifdef SNAKE_GRID_LINES_EN
    logic [9:0] x_d [L];
    logic [9:0] y_d [L];

    // Carry the coordinate alongside the controls for the grid lookup
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            for (int i = 0; i < L; i++) begin
                x_d[i] <= '0;
                y_d[i] <= '0;
            end
        end else begin
            x_d[0] <= h_cnt;
            y_d[0] <= v_cnt;
            for (int i = 1; i < L; i++) begin
                x_d[i] <= x_d[i-1];
                y_d[i] <= y_d[i-1];
            end
        end
    end

    assign grid = (x_d[L-1] % 10'(H_SQUARE) == 10'd0)
               || (y_d[L-1] % 10'(V_SQUARE) == 10'd0);
`else
    assign grid = 1'b0;
`endif

    // Colour of the aligned pixel; blanking forces black
    always_comb begin
        pixel = '0;
        if (active_d[L-1]) begin
            unique case (entity_t'(entity))
                ENT_SNAKE_HEAD: pixel = COL_HEAD;
                ENT_SNAKE_TAIL: pixel = COL_TAIL;
                ENT_APPLE:      pixel = COL_APPLE;
                default:        pixel = grid ? COL_GRID
                                             : bg_colour(game_over, game_won);
            endcase
        end
    end

    // Final output register shared by colour and sync
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            hsync <= 1'b1;
            vsync <= 1'b1;
            rgb   <= '0;
        end else begin
            hsync <= hs_d[L-1];
            vsync <= vs_d[L-1];
            rgb   <= pixel;
        end
    end

    assign red   = rgb[11:8];
    assign green = rgb[7:4];
    assign blue  = rgb[3:0];

    // Count frames; the wrapping frame also fires the game update
    always_ff @(posedge vga_clk) begin
        if (reset)
            frame_cnt <= '0;
        else if (frame_tick)
            frame_cnt <= (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + 8'd1;
    end

    assign update_tick = frame_tick && (frame_cnt == FRAME_LAST);

endmodule

// File: tb/tb_snake_vga_renderer.sv
// Self-checking bench for snake_vga_renderer using a shrunken raster so that
// many frames fit in a short run; expectations come from a raster-index model.
module tb_snake_vga_renderer;

    localparam int HV = 40, HF = 4, HS = 8, HB = 6;
    localparam int VV = 20, VF = 2, VS = 2, VB = 3;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam int FPU = 3;
    localparam int AX = 10, AY = 5;
    localparam int SQ = 16;

    logic       vga_clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] entity = 2'd0;
    logic       game_over = 1'b0;
    logic       game_won = 1'b0;
    logic [9:0] x_out, y_out;
    logic       hsync, vsync;
    logic [3:0] red, green, blue;
    logic       frame_tick, update_tick;
    logic [11:0] rgb;

    int vectors = 0;
    int miscompares = 0;

    int t;
    int fcount;
    int mode;
    logic [1:0]  ent_p;
    logic        ov_p, wn_p;
    int          exp_x, exp_y;
    logic        exp_hs, exp_vs, exp_ft, exp_ut;
    logic [11:0] exp_rgb;

    assign rgb = {red, green, blue};

    snake_vga_renderer #(
        .H_VISIBLE (HV), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
        .V_VISIBLE (VV), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
        .ENTITY_LATENCY (1), .FRAMES_PER_UPDATE (FPU)
    ) dut (
        .vga_clk     (vga_clk),
        .reset       (reset),
        .entity      (entity),
        .game_over   (game_over),
        .game_won    (game_won),
        .x_out       (x_out),
        .y_out       (y_out),
        .hsync       (hsync),
        .vsync       (vsync),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .frame_tick  (frame_tick),
        .update_tick (update_tick)
    );

    always #20 vga_clk = ~vga_clk;

    function automatic logic [11:0] ref_pixel(int x, int y, logic [1:0] e,
                                              logic ov, logic wn);
        if (x >= HV || y >= VV) return 12'h000;
        case (e)
            2'd1: return 12'hFF0;
            2'd2: return 12'h0A0;
            2'd3: return 12'hF00;
            default: begin
`ifdef SNAKE_GRID_LINES_EN
                if (x % SQ == 0 || y % SQ == 0) return 12'h222;
`endif
                if (wn) return 12'h006;
                if (ov) return 12'h400;
                return 12'h000;
            end
        endcase
    endfunction

    // Expected outputs for raster index t (cycles since reset released).
    task automatic update_model();
        int x2, y2;
        exp_x  = t % HT;
        exp_y  = (t / HT) % VT;
        exp_ft = (exp_x == 0) && (exp_y == VV);
        if (exp_ft) fcount++;
        exp_ut = exp_ft && (fcount % FPU == 0);
        if (t < 2) begin
            exp_hs  = 1'b1;
            exp_vs  = 1'b1;
            exp_rgb = 12'h000;
        end else begin
            x2 = (t - 2) % HT;
            y2 = ((t - 2) / HT) % VT;
            exp_hs  = !(x2 >= HV + HF && x2 < HV + HF + HS);
            exp_vs  = !(y2 >= VV + VF && y2 < VV + VF + VS);
            exp_rgb = ref_pixel(x2, y2, ent_p, ov_p, wn_p);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge vga_clk);
        #1;
        reset = 1'b0;
        t = 0;
        fcount = 0;
        update_model();
    endtask

    task automatic step();
        logic [1:0] e;
        logic       o, w;
        logic [9:0] px, py;
        e  = entity;
        o  = game_over;
        w  = game_won;
        px = x_out;
        py = y_out;
        @(posedge vga_clk);
        #1;
        t++;
        ent_p = e;
        ov_p  = o;
        wn_p  = w;
        update_model();
        case (mode)
            0: begin
                entity    = 2'($urandom_range(0, 3));
                game_over = 1'($urandom_range(0, 1));
                game_won  = ($urandom_range(0, 7) == 0);
            end
            1: entity = (px == 10'(AX) && py == 10'(AY)) ? 2'd3 : 2'd0;
            default: ;
        endcase
    endtask

    task automatic test_reset();
        mode = 2;
        entity = 2'd1;
        game_over = 1'b0;
        game_won = 1'b0;
        do_reset();
        vectors++;
        if ({x_out, y_out} !== 20'd0) begin
            miscompares++;
            $display("FAIL reset_xy got=%0d,%0d exp=0,0", x_out, y_out);
        end
        vectors++;
        if ({hsync, vsync} !== 2'b11) begin
            miscompares++;
            $display("FAIL reset_sync got=%b%b exp=11", hsync, vsync);
        end
        vectors++;
        if (rgb !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_rgb got=%h exp=000", rgb);
        end
        vectors++;
        if ({frame_tick, update_tick} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_ticks got=%b%b exp=00", frame_tick, update_tick);
        end
        repeat (2) begin
            step();
            vectors++;
            if ({hsync, vsync, rgb} !== {exp_hs, exp_vs, exp_rgb}) begin
                miscompares++;
                $display("FAIL reset_drain t=%0d got=%b%b %h exp=%b%b %h",
                         t, hsync, vsync, rgb, exp_hs, exp_vs, exp_rgb);
            end
        end
    endtask

    task automatic test_timing();
        int hs_low, vs_low;
        logic prev;
        hs_low = 0;
        vs_low = 0;
        mode = 0;
        do_reset();
        prev = hsync;
        while (t < 2 * FT + 1) begin
            step();
            vectors++;
            if ({x_out, y_out, hsync, vsync, rgb} !==
                {10'(exp_x), 10'(exp_y), exp_hs, exp_vs, exp_rgb}) begin
                miscompares++;
                $display("FAIL timing t=%0d got=%0d,%0d %b%b %h exp=%0d,%0d %b%b %h",
                         t, x_out, y_out, hsync, vsync, rgb,
                         exp_x, exp_y, exp_hs, exp_vs, exp_rgb);
            end
            if (t >= 2 && !hsync) hs_low++;
            if (t >= 2 && !vsync) vs_low++;
            if (prev && !hsync) begin
                vectors++;
                if (exp_x != (HV + HF + 2) % HT) begin
                    miscompares++;
                    $display("FAIL hsync_fall got_h=%0d exp_h=%0d", exp_x,
                             (HV + HF + 2) % HT);
                end
            end
            prev = hsync;
        end
        vectors++;
        if (hs_low != 2 * VT * HS) begin
            miscompares++;
            $display("FAIL hsync_low_count got=%0d exp=%0d", hs_low, 2 * VT * HS);
        end
        vectors++;
        if (vs_low != 2 * VS * HT) begin
            miscompares++;
            $display("FAIL vsync_low_count got=%0d exp=%0d", vs_low, 2 * VS * HT);
        end
    endtask

    task automatic test_apple();
        int hits;
        hits = 0;
        mode = 1;
        game_over = 1'b0;
        game_won = 1'b0;
        do_reset();
        repeat (FT + 2) begin
            step();
            vectors++;
            if (rgb !== exp_rgb) begin
                miscompares++;
                $display("FAIL apple_rgb t=%0d got=%h exp=%h", t, rgb, exp_rgb);
            end
            if (rgb === 12'hF00) begin
                hits++;
                vectors++;
                if (exp_x != AX + 2 || exp_y != AY) begin
                    miscompares++;
                    $display("FAIL apple_pos got=%0d,%0d exp=%0d,%0d",
                             exp_x, exp_y, AX + 2, AY);
                end
            end
        end
        vectors++;
        if (hits != 1) begin
            miscompares++;
            $display("FAIL apple_hits got=%0d exp=1", hits);
        end
    endtask

    task automatic test_blank_head();
        int blank_lit;
        blank_lit = 0;
        mode = 2;
        entity = 2'd1;
        game_over = 1'b0;
        game_won = 1'b0;
        do_reset();
        repeat (2 * HT + 2) begin
            step();
            vectors++;
            if (rgb !== exp_rgb) begin
                miscompares++;
                $display("FAIL head_rgb t=%0d got=%h exp=%h", t, rgb, exp_rgb);
            end
            if (t >= 2 && (t - 2) % HT >= HV && rgb !== 12'h000) blank_lit++;
        end
        vectors++;
        if (blank_lit != 0) begin
            miscompares++;
            $display("FAIL head_blank got=%0d lit exp=0", blank_lit);
        end
    endtask

    task automatic test_background();
        int n;
        mode = 2;
        entity = 2'd0;
        game_over = 1'b1;
        game_won = 1'b0;
        repeat (HT) begin
            step();
            vectors++;
            if (rgb !== exp_rgb) begin
                miscompares++;
                $display("FAIL over_rgb t=%0d got=%h exp=%h", t, rgb, exp_rgb);
            end
        end
        n = 0;
        while (n < FT && !(exp_x == 21 && exp_y == 3)) begin
            step();
            n++;
        end
        vectors++;
        if (n >= FT) begin
            miscompares++;
            $display("FAIL bg_wait timeout got=%0d exp<%0d", n, FT);
        end
        vectors++;
        if (rgb !== 12'h400) begin
            miscompares++;
            $display("FAIL bg_over got=%h exp=400", rgb);
        end
        game_won = 1'b1;
        step();
        step();
        vectors++;
        if (rgb !== 12'h006) begin
            miscompares++;
            $display("FAIL bg_won got=%h exp=006", rgb);
        end
        repeat (HT) begin
            step();
            vectors++;
            if (rgb !== exp_rgb) begin
                miscompares++;
                $display("FAIL won_rgb t=%0d got=%h exp=%h", t, rgb, exp_rgb);
            end
        end
    endtask

    task automatic test_update();
        int nft, nut;
        nft = 0;
        nut = 0;
        mode = 0;
        do_reset();
        repeat (7 * FT) begin
            step();
            vectors++;
            if ({frame_tick, update_tick} !== {exp_ft, exp_ut}) begin
                miscompares++;
                $display("FAIL ticks t=%0d got=%b%b exp=%b%b",
                         t, frame_tick, update_tick, exp_ft, exp_ut);
            end
            if (frame_tick === 1'b1) nft++;
            if (update_tick === 1'b1) begin
                nut++;
                vectors++;
                if (nft % FPU != 0) begin
                    miscompares++;
                    $display("FAIL update_slot got=%0d exp_mult_of=%0d", nft, FPU);
                end
            end
        end
        vectors++;
        if (nft != 7) begin
            miscompares++;
            $display("FAIL frame_count got=%0d exp=7", nft);
        end
        vectors++;
        if (nut != 2) begin
            miscompares++;
            $display("FAIL update_count got=%0d exp=2", nut);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        mode = 0;
        n = 0;
        while (n < FT && !(exp_x == HV + HF + 2 && exp_y == 15)) begin
            step();
            n++;
        end
        vectors++;
        if (n >= FT || hsync !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_wait got=%0d hs=%b exp<%0d hs=0", n, hsync, FT);
        end
        mode = 2;
        entity = 2'd0;
        game_over = 1'b0;
        game_won = 1'b0;
        do_reset();
        vectors++;
        if ({x_out, y_out, hsync, vsync, rgb} !== {20'd0, 2'b11, 12'h000}) begin
            miscompares++;
            $display("FAIL mid_reset got=%0d,%0d %b%b %h exp=0,0 11 000",
                     x_out, y_out, hsync, vsync, rgb);
        end
        repeat (2 * HT + 2) begin
            step();
            vectors++;
            if ({hsync, vsync, rgb} !== {exp_hs, exp_vs, exp_rgb}) begin
                miscompares++;
                $display("FAIL mid_after t=%0d got=%b%b %h exp=%b%b %h",
                         t, hsync, vsync, rgb, exp_hs, exp_vs, exp_rgb);
            end
        end
    endtask

    initial begin
        mode = 2;
        t = 0;
        fcount = 0;
        ent_p = 2'd0;
        ov_p = 1'b0;
        wn_p = 1'b0;
        test_reset();
        test_timing();
        test_apple();
        test_blank_head();
        test_background();
        test_update();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
